// File: rtl/dht11_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dht11_pkg : shared FSM encoding, frame/counter widths, checksum helper
// Rev 1.0
// ---------------------------------------------------------------------------
package dht11_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_LOW = 3'd1,
    S_WAIT_RESP = 3'd2,
    S_RESP_LOW  = 3'd3,
    S_RESP_HIGH = 3'd4,
    S_DATA_LOW  = 3'd5,
    S_DATA_HIGH = 3'd6,
    S_CHECK     = 3'd7
  } state_t;

  localparam int FRAME_W  = 40;
  localparam int US_W     = 15;
  localparam int BITCNT_W = 6;

  // Frame is MSB-first: byte0 occupies [39:32], checksum byte4 occupies [7:0].
  function automatic logic checksum_ok(input logic [FRAME_W-1:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detector_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_edge_detector_n : 2-FF synchronizer with one-cycle rise/fall pulses
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_edge_detector_n (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o =  sync_q & ~prev_q;
  assign fall_o = ~sync_q &  prev_q;

endmodule
`default_nettype wire

// File: rtl/dht11_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dht11_ctrl : DHT11 single-wire host; start pulse, 40-bit capture, checksum
// Rev 1.0
// ---------------------------------------------------------------------------
module dht11_ctrl
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 40,
  parameter int TIMEOUT_US    = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       valid,
  output logic       error
);

  localparam int DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]       C_PRESC_LAST = PW'(DIV - 1);
  localparam logic [US_W-1:0]     C_START_CNT  = US_W'(START_LOW_US);
  localparam logic [US_W-1:0]     C_THRESH     = US_W'(BIT_THRESH_US);
  localparam logic [US_W-1:0]     C_TMO_PRE    = US_W'(TIMEOUT_US - 1);
  localparam logic [BITCNT_W-1:0] C_FRAME_BITS = BITCNT_W'(FRAME_W);

  state_t               state_q;
  logic [PW-1:0]        presc_q;
  logic [US_W-1:0]      us_q;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic                 dht_oe_q, busy_q, valid_q, error_q;
  logic [7:0]           hum_q, temp_q;

  logic rise_w, fall_w, edge_w, tick_w, bit_w, waiting_w, timeout_w;

  sync_edge_detector_n u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (dht_in),
    .rise_o  (rise_w),
    .fall_o  (fall_w)
  );

  assign edge_w    = rise_w | fall_w;
  assign tick_w    = (presc_q == C_PRESC_LAST);
  assign bit_w     = (us_q > C_THRESH);
  assign shreg_d   = {shreg_q[FRAME_W-2:0], bit_w};
  assign bitcnt_d  = bitcnt_q + 1'b1;
  assign waiting_w = (state_q inside {S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH,
                                      S_DATA_LOW, S_DATA_HIGH});
  // Abort on the tick that carries the counter onto TIMEOUT_US.
  assign timeout_w = waiting_w && !edge_w && tick_w && (us_q == C_TMO_PRE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      us_q     <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      dht_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      hum_q    <= '0;
      temp_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;

      if (edge_w) begin
        presc_q <= '0;
        us_q    <= '0;
      end else if (tick_w) begin
        presc_q <= '0;
        if (!(&us_q)) us_q <= us_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end

      // Every branch that changes state also restarts the us timebase.
      case (state_q)
        S_IDLE: if (start) begin
          state_q  <= S_START_LOW;
          dht_oe_q <= 1'b1;
          busy_q   <= 1'b1;
          shreg_q  <= '0;
          bitcnt_q <= '0;
          presc_q  <= '0;
          us_q     <= '0;
        end
        S_START_LOW: if (us_q == C_START_CNT) begin
          state_q  <= S_WAIT_RESP;
          dht_oe_q <= 1'b0;
          presc_q  <= '0;
          us_q     <= '0;
        end
        S_WAIT_RESP: if (fall_w) state_q <= S_RESP_LOW;
        S_RESP_LOW:  if (rise_w) state_q <= S_RESP_HIGH;
        S_RESP_HIGH: if (fall_w) state_q <= S_DATA_LOW;
        S_DATA_LOW:  if (rise_w) state_q <= S_DATA_HIGH;
        S_DATA_HIGH: if (fall_w) begin
          shreg_q  <= shreg_d;
          bitcnt_q <= bitcnt_d;
          state_q  <= (bitcnt_d == C_FRAME_BITS) ? S_CHECK : S_DATA_LOW;
        end
        S_CHECK: begin
          if (checksum_ok(shreg_q)) begin
            hum_q   <= shreg_q[39:32];
            temp_q  <= shreg_q[23:16];
            valid_q <= 1'b1;
          end else begin
            error_q <= 1'b1;
          end
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          presc_q <= '0;
          us_q    <= '0;
        end
        default: state_q <= S_IDLE;
      endcase

      if (timeout_w) begin
        state_q  <= S_IDLE;
        error_q  <= 1'b1;
        dht_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        presc_q  <= '0;
        us_q     <= '0;
      end
    end
  end

  assign dht_oe      = dht_oe_q;
  assign busy        = busy_q;
  assign humidity    = hum_q;
  assign temperature = temp_q;
  assign valid       = valid_q;
  assign error       = error_q;

endmodule
`default_nettype wire

// File: tb/tb_dht11_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dht11_ctrl : sensor model + scoreboard bench for dht11_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dht11_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       sens_low = 1'b0;
  wire        dht_in;
  logic       dht_oe, busy, valid, error;
  logic [7:0] humidity, temperature;

  always #5 clk = ~clk;

  // Open-drain line with pull-up: low if either side drives it.
  assign dht_in = (dht_oe | sens_low) ? 1'b0 : 1'b1;

  dht11_ctrl #(
    .CLK_FREQ_HZ   (1_000_000),
    .START_LOW_US  (100),
    .BIT_THRESH_US (40),
    .TIMEOUT_US    (200)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dht_in      (dht_in),
    .dht_oe      (dht_oe),
    .busy        (busy),
    .humidity    (humidity),
    .temperature (temperature),
    .valid       (valid),
    .error       (error)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] hum;
    logic [7:0] temp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vcnt = 0, ecnt = 0, overlap = 0;
  int   cyc = 0, err_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n && (valid || error)) begin
      exp_t e;
      if (valid && error) overlap++;
      if (valid) vcnt++;
      if (error) begin ecnt++; err_cyc = cyc; end
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: valid=%0b error=%0b with no expected result", valid, error);
      end else begin
        e = sb_q.pop_front();
        if (error !== e.is_err || valid !== !e.is_err || humidity !== e.hum || temperature !== e.temp)
          $display("FAIL sb_result: got err=%0b hum=%h temp=%h, required err=%0b hum=%h temp=%h",
                   error, humidity, temperature, e.is_err, e.hum, e.temp);
        else n_pass++;
      end
    end
  end

  function automatic logic [39:0] mk_frame(input logic [7:0] b0, b1, b2, b3, b4);
    return {b0, b1, b2, b3, b4};
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Waits for the host to release the line; reports whether it did in time.
  task automatic wait_release(output bit ok);
    for (int i = 0; i < 300 && !dht_oe; i++) @(negedge clk);
    for (int i = 0; i < 300 && dht_oe; i++) @(negedge clk);
    ok = !dht_oe && busy;
  endtask

  task automatic sensor_frame(input logic [39:0] frame, input bit second_start);
    bit ok;
    wait_release(ok);
    n_checks++;
    if (!ok) begin
      $display("FAIL release_wait: dht_oe=%0b busy=%0b, required 0/1", dht_oe, busy);
      return;
    end
    n_pass++;
    repeat (20) @(negedge clk);
    sens_low = 1'b1; repeat (80) @(negedge clk);
    sens_low = 1'b0; repeat (80) @(negedge clk);
    for (int i = 39; i >= 0; i--) begin
      sens_low = 1'b1;
      if (second_start && i == 20) begin
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (49) @(negedge clk);
      end else begin
        repeat (50) @(negedge clk);
      end
      sens_low = 1'b0;
      repeat (frame[i] ? 70 : 26) @(negedge clk);
    end
    sens_low = 1'b1; repeat (50) @(negedge clk);
    sens_low = 1'b0; repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (dht_oe !== 1'b0) $display("FAIL rst_oe: got %b required 0", dht_oe); else n_pass++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
    if (valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", valid); else n_pass++;
    if (error !== 1'b0) $display("FAIL rst_error: got %b required 0", error); else n_pass++;
    if (humidity !== 8'h00) $display("FAIL rst_hum: got %h required 00", humidity); else n_pass++;
    if (temperature !== 8'h00) $display("FAIL rst_temp: got %h required 00", temperature); else n_pass++;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int v0 = vcnt, e0 = ecnt;
    sb_q.push_back('{is_err: 1'b0, hum: 8'h37, temp: 8'h19});
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || dht_oe !== 1'b1) $display("FAIL start_busy_oe: got %b/%b required 1/1", busy, dht_oe);
    else n_pass++;
    sensor_frame(mk_frame(8'h37, 8'h00, 8'h19, 8'h00, 8'h50), 1'b0);
    n_checks += 5;
    if (vcnt - v0 !== 1) $display("FAIL good_valid_cnt: got %0d required 1", vcnt - v0); else n_pass++;
    if (ecnt - e0 !== 0) $display("FAIL good_error_cnt: got %0d required 0", ecnt - e0); else n_pass++;
    if (humidity !== 8'h37) $display("FAIL good_hum: got %h required 37", humidity); else n_pass++;
    if (temperature !== 8'h19) $display("FAIL good_temp: got %h required 19", temperature); else n_pass++;
    if (busy !== 1'b0) $display("FAIL good_busy: got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_bad_checksum();
    int v0 = vcnt, e0 = ecnt;
    sb_q.push_back('{is_err: 1'b1, hum: 8'h37, temp: 8'h19});
    pulse_start();
    sensor_frame(mk_frame(8'h37, 8'h00, 8'h19, 8'h00, 8'h51), 1'b0);
    n_checks += 4;
    if (ecnt - e0 !== 1) $display("FAIL bad_error_cnt: got %0d required 1", ecnt - e0); else n_pass++;
    if (vcnt - v0 !== 0) $display("FAIL bad_valid_cnt: got %0d required 0", vcnt - v0); else n_pass++;
    if (humidity !== 8'h37) $display("FAIL bad_hum_hold: got %h required 37", humidity); else n_pass++;
    if (temperature !== 8'h19) $display("FAIL bad_temp_hold: got %h required 19", temperature); else n_pass++;
  endtask

  task automatic test_timeout();
    int e0 = ecnt, t0, dt;
    sb_q.push_back('{is_err: 1'b1, hum: 8'h37, temp: 8'h19});
    pulse_start();
    for (int i = 0; i < 300 && dht_oe; i++) @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 400 && ecnt == e0; i++) @(negedge clk);
    n_checks += 4;
    if (ecnt - e0 !== 1) begin
      $display("FAIL tmo_error_cnt: got %0d required 1", ecnt - e0);
    end else n_pass++;
    dt = err_cyc - t0;
    if (ecnt == e0 || dt < 197 || dt > 203) $display("FAIL tmo_delay: got %0d clk required 200+-3", dt);
    else n_pass++;
    @(negedge clk);
    if (busy !== 1'b0) $display("FAIL tmo_busy: got %b required 0", busy); else n_pass++;
    if (dht_oe !== 1'b0) $display("FAIL tmo_oe: got %b required 0", dht_oe); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int v0 = vcnt, e0 = ecnt;
    // 0x96/0x29 mix short and long highs; a start arrives mid-frame.
    sb_q.push_back('{is_err: 1'b0, hum: 8'h96, temp: 8'h29});
    pulse_start();
    sensor_frame(mk_frame(8'h96, 8'h01, 8'h29, 8'h03, 8'hC3), 1'b1);
    repeat (150) @(negedge clk);
    n_checks += 5;
    if (vcnt - v0 !== 1) $display("FAIL b2b_valid_cnt: got %0d required 1", vcnt - v0); else n_pass++;
    if (ecnt - e0 !== 0) $display("FAIL b2b_error_cnt: got %0d required 0", ecnt - e0); else n_pass++;
    if (humidity !== 8'h96) $display("FAIL b2b_hum: got %h required 96", humidity); else n_pass++;
    if (temperature !== 8'h29) $display("FAIL b2b_temp: got %h required 29", temperature); else n_pass++;
    if (busy !== 1'b0 || dht_oe !== 1'b0) $display("FAIL b2b_idle: busy/oe got %b/%b required 0/0", busy, dht_oe);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int v0 = vcnt, e0 = ecnt;
    bit ok;
    pulse_start();
    wait_release(ok);
    repeat (20) @(negedge clk);
    sens_low = 1'b1;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (dht_oe !== 1'b0) $display("FAIL mid_rst_oe: got %b required 0", dht_oe); else n_pass++;
    if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b required 0", busy); else n_pass++;
    if (humidity !== 8'h00 || temperature !== 8'h00)
      $display("FAIL mid_rst_data: got %h/%h required 00/00", humidity, temperature);
    else n_pass++;
    if (valid !== 1'b0 || error !== 1'b0) $display("FAIL mid_rst_pulse: got %b/%b required 0/0", valid, error);
    else n_pass++;
    @(negedge clk);
    reset_n  = 1'b1;
    sens_low = 1'b0;
    repeat (300) @(negedge clk);
    n_checks += 2;
    if (vcnt != v0 || ecnt != e0) $display("FAIL mid_rst_no_pulse: got v=%0d e=%0d required 0/0", vcnt - v0, ecnt - e0);
    else n_pass++;
    if (busy !== 1'b0) $display("FAIL mid_rst_idle: got %b required 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    n_checks += 2;
    if (overlap != 0) $display("FAIL valid_error_overlap: got %0d required 0", overlap); else n_pass++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d required 0", sb_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
